// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and dimension check for the matrix loader and AddUnit.
package matrix_pkg;

    localparam int MAX_DIM    = 5;
    localparam int ELEM_WIDTH = 8;
    localparam int MAX_ELEM   = MAX_DIM * MAX_DIM;
    localparam int BUS_WIDTH  = MAX_ELEM * ELEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic dims_legal(input logic [2:0] m, input logic [2:0] n);
        return (m != 3'd0) && (m <= 3'(MAX_DIM)) && (n != 3'd0) && (n <= 3'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Row/column position counter for a row-major load; wraps columns at n and flags (m-1, n-1).
module matrix_idx_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] m,
    input  logic [2:0] n,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic col_wrap;

    assign col_wrap = (col == n - 3'd1);
    assign last     = (row == m - 3'd1) && col_wrap;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (clear) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= 3'd0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Collects an m x n matrix over a valid/ready stream and packs it row-major into the AddUnit bus.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            m_in,
    input  logic [2:0]            n_in,
    input  logic [ELEM_WIDTH-1:0] elem_in,
    input  logic                  elem_valid,
    output logic                  elem_ready,
    output logic [BUS_WIDTH-1:0]  matrix_out,
    output logic [2:0]            m_out,
    output logic [2:0]            n_out,
    output logic                  matrix_valid,
    output logic                  busy,
    output logic [4:0]            elem_cnt,
    output logic                  err
);

    state_t     state, next_state;
    logic       load_go, clr, err_set, do_write, last;
    logic [2:0] row, col;
    logic [4:0] slot;
    logic [5:0] dim_prod;

    assign busy         = (state == LOAD);
    assign elem_ready   = busy;
    assign matrix_valid = (state == DONE);

    assign do_write = busy && elem_valid && !abort;
    assign slot     = 5'(row) * 5'(MAX_DIM) + 5'(col);
    assign dim_prod = 6'(m_out) * 6'(n_out);

    matrix_idx_counter u_idx (
        .clk     (clk),
        .reset   (reset),
        .clear   (load_go | clr),
        .advance (do_write),
        .m       (m_out),
        .n       (n_out),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        load_go    = 1'b0;
        clr        = 1'b0;
        err_set    = 1'b0;
        case (state)
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                    clr        = 1'b1;
                end else if (do_write && last) begin
                    next_state = DONE;
                end
            end
            IDLE, DONE: begin
                // abort is meaningless in IDLE, so only DONE lets it pre-empt a start
                if (abort && state == DONE) begin
                    next_state = IDLE;
                    clr        = 1'b1;
                end else if (start) begin
                    if (dims_legal(m_in, n_in)) begin
                        next_state = LOAD;
                        load_go    = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the packing bus is a flop bank with a defined reset value, not a RAM, so it is reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix_out <= '0;
            m_out      <= 3'd0;
            n_out      <= 3'd0;
            elem_cnt   <= 5'd0;
            err        <= 1'b0;
        end else begin
            err <= err_set;
            if (load_go) begin
                matrix_out <= '0;
                m_out      <= m_in;
                n_out      <= n_in;
                elem_cnt   <= 5'd0;
            end else if (clr) begin
                matrix_out <= '0;
                m_out      <= 3'd0;
                n_out      <= 3'd0;
                elem_cnt   <= 5'd0;
            end else if (do_write) begin
                matrix_out[slot*ELEM_WIDTH +: ELEM_WIDTH] <= elem_in;
                if ({1'b0, elem_cnt} < dim_prod) elem_cnt <= elem_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed, table-driven bench for matrix_loader with hand-written multi-cycle sequences.
module tb_matrix_loader;
    import matrix_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start, abort, elem_valid;
    logic [2:0]           m_in, n_in;
    logic [7:0]           elem_in;
    logic                 elem_ready, matrix_valid, busy, err;
    logic [BUS_WIDTH-1:0] matrix_out, exp_bus;
    logic [2:0]           m_out, n_out;
    logic [4:0]           elem_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] m;
        logic [2:0] n;
        logic       exp_err;
    } dim_vec_t;

    dim_vec_t vecs[8];

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .m_in         (m_in),
        .n_in         (n_in),
        .elem_in      (elem_in),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .matrix_out   (matrix_out),
        .m_out        (m_out),
        .n_out        (n_out),
        .matrix_valid (matrix_valid),
        .busy         (busy),
        .elem_cnt     (elem_cnt),
        .err          (err)
    );

    task automatic check(input string name, input logic [BUS_WIDTH-1:0] act,
                         input logic [BUS_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] m, input logic [2:0] n);
        start = 1'b1; m_in = m; n_in = n;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        elem_valid = 1'b1; elem_in = v;
        step();
        elem_valid = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic [7:0] v);
        exp_bus[s*8 +: 8] = v;
    endtask

    initial begin
        int done_at;
        int xfers;

        vecs[0] = '{3'd0, 3'd3, 1'b1};
        vecs[1] = '{3'd6, 3'd2, 1'b1};
        vecs[2] = '{3'd1, 3'd0, 1'b1};
        vecs[3] = '{3'd7, 3'd7, 1'b1};
        vecs[4] = '{3'd5, 3'd6, 1'b1};
        vecs[5] = '{3'd1, 3'd1, 1'b0};
        vecs[6] = '{3'd5, 3'd5, 1'b0};
        vecs[7] = '{3'd3, 3'd4, 1'b0};

        reset = 1'b0; start = 1'b0; abort = 1'b0; elem_valid = 1'b0;
        m_in = 3'd0; n_in = 3'd0; elem_in = 8'd0;
        #12;
        check("rst_matrix", matrix_out, '0);
        check("rst_valid", matrix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", elem_ready, 0);
        check("rst_cnt", elem_cnt, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        step();

        // 2x3 back-to-back
        do_start(3'd2, 3'd3);
        check("t1_busy", busy, 1);
        check("t1_mout", m_out, 2);
        check("t1_nout", n_out, 3);
        for (int k = 1; k <= 6; k++) begin
            check("t1_ready", elem_ready, 1);
            check("t1_not_valid", matrix_valid, 0);
            push(8'(k));
        end
        check("t1_valid_at_7", matrix_valid, 1);
        check("t1_busy_off", busy, 0);
        exp_bus = '0;
        set_slot(0, 8'd1); set_slot(1, 8'd2); set_slot(2, 8'd3);
        set_slot(5, 8'd4); set_slot(6, 8'd5); set_slot(7, 8'd6);
        check("t1_matrix", matrix_out, exp_bus);
        check("t1_cnt", elem_cnt, 6);
        step();
        check("t1_hold", matrix_out, exp_bus);

        // 5x5 with elem_valid toggling
        do_start(3'd5, 3'd5);
        done_at = -1;
        xfers = 0;
        for (int i = 0; i < 60; i++) begin
            elem_valid = (i % 2 == 0); elem_in = 8'hFF;
            if (elem_valid && elem_ready) xfers++;
            step();
            if (matrix_valid) begin
                done_at = i;
                break;
            end
        end
        elem_valid = 1'b0;
        check("t2_done_cycle", done_at, 48);
        check("t2_xfers", xfers, 25);
        check("t2_cnt", elem_cnt, 25);
        check("t2_matrix", matrix_out, {BUS_WIDTH{1'b1}});

        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_idle", matrix_valid, 0);
        check("abort_done_mout", m_out, 0);
        check("abort_done_matrix", matrix_out, '0);

        // dimension table from IDLE
        for (int v = 0; v < 8; v++) begin
            do_start(vecs[v].m, vecs[v].n);
            check($sformatf("dim%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("dim%0d_busy", v), busy, !vecs[v].exp_err);
            check($sformatf("dim%0d_ready", v), elem_ready, !vecs[v].exp_err);
            check($sformatf("dim%0d_mout", v), m_out, vecs[v].exp_err ? 3'd0 : vecs[v].m);
            check($sformatf("dim%0d_nout", v), n_out, vecs[v].exp_err ? 3'd0 : vecs[v].n);
            step();
            check($sformatf("dim%0d_err_pulse", v), err, 0);
            if (!vecs[v].exp_err) begin
                start = 1'b1; m_in = 3'd0;
                step();
                start = 1'b0;
                check($sformatf("dim%0d_start_in_load", v), err, 0);
                abort = 1'b1;
                step();
                abort = 1'b0;
                check($sformatf("dim%0d_abort", v), busy, 0);
            end
        end

        // 3x3 aborted with a same-cycle transfer
        do_start(3'd3, 3'd3);
        for (int k = 0; k < 4; k++) push(8'(11 + k));
        exp_bus = '0;
        set_slot(0, 8'd11); set_slot(1, 8'd12); set_slot(2, 8'd13); set_slot(5, 8'd14);
        check("t4_partial", matrix_out, exp_bus);
        check("t4_cnt4", elem_cnt, 4);
        abort = 1'b1; elem_valid = 1'b1; elem_in = 8'h55;
        step();
        abort = 1'b0; elem_valid = 1'b0;
        check("t4_idle", busy, 0);
        check("t4_matrix", matrix_out, '0);
        check("t4_cnt", elem_cnt, 0);
        check("t4_valid", matrix_valid, 0);

        // 1x1 then restart from DONE
        do_start(3'd1, 3'd1);
        push(8'h2A);
        check("t5_valid", matrix_valid, 1);
        check("t5_matrix", matrix_out, BUS_WIDTH'(8'h2A));
        do_start(3'd2, 3'd2);
        check("t5_valid_drop", matrix_valid, 0);
        check("t5_busy", busy, 1);
        check("t5_cleared", matrix_out, '0);
        check("t5_mout", m_out, 2);
        for (int k = 0; k < 4; k++) push(8'(8'hA0 + k));
        exp_bus = '0;
        set_slot(0, 8'hA0); set_slot(1, 8'hA1); set_slot(5, 8'hA2); set_slot(6, 8'hA3);
        check("t5_valid2", matrix_valid, 1);
        check("t5_matrix2", matrix_out, exp_bus);

        // async reset mid-load
        do_start(3'd4, 3'd4);
        for (int k = 0; k < 7; k++) push(8'(k + 1));
        check("t6_cnt7", elem_cnt, 7);
        #1 reset = 1'b0;
        #1;
        check("t6_matrix", matrix_out, '0);
        check("t6_busy", busy, 0);
        check("t6_cnt", elem_cnt, 0);
        check("t6_mout", m_out, 0);
        check("t6_ready", elem_ready, 0);
        #1 reset = 1'b1;
        step();
        do_start(3'd2, 3'd1);
        push(8'd7);
        push(8'd8);
        exp_bus = '0;
        set_slot(0, 8'd7); set_slot(5, 8'd8);
        check("t6_fresh_valid", matrix_valid, 1);
        check("t6_fresh_matrix", matrix_out, exp_bus);
        check("t6_fresh_cnt", elem_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
